multi_cycle_control: RTL

- Multi-cycle MIPS main control FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and write enables.
- Produces the 3-bit alu_op code consumed by the ALU control decoder. It is the encoding end of the alu_op interface.

---
 rtl/multi_cycle_control_pkg.sv | 60 ++++++
 rtl/control_opcode_class.sv | 23 ++
 rtl/multi_cycle_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg: state, opcode, alu_op and datapath select encodings shared by the control FSM.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JR
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_JR, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Must match the ALU control decoder bit-for-bit.
    localparam logic [2:0] ALU_R   = 3'b111;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_LUI = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_BOFF = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    function automatic logic [2:0] i_alu_op(input logic [5:0] op);
        return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
    endfunction

    function automatic logic is_zext(input logic [5:0] op);
        return op == OP_ANDI || op == OP_ORI;
    endfunction

endpackage

// File: rtl/control_opcode_class.sv
// control_opcode_class: maps opcode/funct to the instruction class that steers the control FSM.
module control_opcode_class
    import multi_cycle_control_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE:                       cls = funct == FN_JR ? CLS_JR : CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: cls = CLS_I;
            OP_LW:                          cls = CLS_LOAD;
            OP_SW:                          cls = CLS_STORE;
            OP_BEQ, OP_BNE:                 cls = CLS_BRANCH;
            OP_J, OP_JAL:                   cls = CLS_JUMP;
            default:                        cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS main control FSM driving datapath selects, write enables and alu_op.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int RA_REG      = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       imm_zext_o,
    output logic [1:0] pc_source_o,
    output logic [2:0] alu_op_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    if (RA_REG < 0 || RA_REG > 31) begin : g_ra_range
        $error("RA_REG must be a 5-bit register index");
    end

    state_t       state, next;
    logic [5:0]   op_q, fn_q;
    instr_class_t cls_now, cls_q;
    logic         ready;

    assign ready   = mem_ready_i | ~MEM_WAIT_EN;
    assign state_o = state;

    control_opcode_class u_cls_now (.opcode(opcode_i), .funct(funct_i), .cls(cls_now));
    control_opcode_class u_cls_q   (.opcode(op_q),     .funct(fn_q),    .cls(cls_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op_q  <= '0;
            fn_q  <= '0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                op_q <= opcode_i;
                fn_q <= funct_i;
            end
        end
    end

    always_comb begin
        next         = state;
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = REG_DST_RT;
        mem_to_reg_o = M2R_ALU;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_REG;
        imm_zext_o   = 1'b0;
        pc_source_o  = PC_SRC_ALU;
        alu_op_o     = ALU_LUI;
        illegal_o    = 1'b0;
        case (state)
            S_IDLE: next = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_ADD;
                pc_source_o = PC_SRC_ALU;
                ir_write_o  = ready;
                pc_write_o  = ready;
                next        = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_o = SRC_B_BOFF;
                alu_op_o    = ALU_ADD;
                illegal_o   = cls_now == CLS_ILLEGAL;
                case (cls_now)
                    CLS_R:               next = S_R_EXEC;
                    CLS_JR:              next = S_JR;
                    CLS_I:               next = S_I_EXEC;
                    CLS_LOAD, CLS_STORE: next = S_MEM_ADDR;
                    CLS_BRANCH:          next = S_BRANCH;
                    CLS_JUMP:            next = S_JUMP;
                    default:             next = S_FETCH;
                endcase
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_REG;
                alu_op_o    = ALU_R;
                next        = S_R_WB;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = REG_DST_RD;
                mem_to_reg_o = M2R_ALU;
                next         = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = i_alu_op(op_q);
                imm_zext_o  = is_zext(op_q);
                next        = S_I_WB;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
                imm_zext_o  = is_zext(op_q);
                next        = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADD;
                next        = cls_q == CLS_LOAD ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                next       = ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = M2R_MDR;
                next         = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                next        = ready ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_REG;
                alu_op_o    = ALU_SUB;
                pc_source_o = PC_SRC_ALUOUT;
                pc_write_o  = (op_q == OP_BEQ && zero_i) || (op_q == OP_BNE && !zero_i);
                next        = S_FETCH;
            end
            S_JUMP: begin
                // PC was already advanced in FETCH, so it is the jal link value.
                pc_write_o   = 1'b1;
                pc_source_o  = PC_SRC_JUMP;
                reg_write_o  = op_q == OP_JAL;
                reg_dst_o    = op_q == OP_JAL ? REG_DST_RA : REG_DST_RT;
                mem_to_reg_o = op_q == OP_JAL ? M2R_PC : M2R_ALU;
                next         = S_FETCH;
            end
            S_JR: begin
                pc_write_o  = 1'b1;
                pc_source_o = PC_SRC_REG;
                alu_op_o    = ALU_R;
                next        = S_FETCH;
            end
            default: next = S_IDLE;
        endcase
    end

endmodule
